instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the 16-byte-block instruction memory.
- Acts as the initiator of the block-read handshake: read, 6-bit block address, busywait, 128-bit block.
- Serves 32-bit instruction fetches from 8 cached blocks and stalls the CPU with busywait on a miss while it fetches the block.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (index width = log2 = 3).
- TAG_W, 3, tag bits; pc[9:7].
- CNT_W, 16, width of the saturating hit and miss counters.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- read  in  1  CPU fetch request.
- pc  in  10  byte address of the instruction; bits [1:0] are ignored.
- instruction  out  32  fetched instruction.
- busywait  out  1  CPU stall.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  6  block address {tag, index}.
- mem_readinst  in  128  block returned by memory; byte 0 at bits [7:0].
- mem_busywait  in  1  memory busy.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Address split: tag = pc[9:7], index = pc[6:4], word = pc[3:2].
- Storage: data[8] x 128 bits, tag[8] x 3 bits, valid[8].
- hit = read && valid[index] && (tag[index] == pc tag). Combinational.
- instruction = data[index] word selected by word:
  - word 0 is bits [31:0], word 3 is bits [127:96];
  - little-endian byte order within the word.
  - Driven only on a hit; 32'h0 otherwise.
- busywait = read && !(state == IDLE && hit). Combinational.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - On read && hit: stay in IDLE; hit_count increments.
  - On read && !hit: latch {tag, index} into miss_addr; miss_count increments; go to MEM_READ.
  - When read = 0: no action.
- MEM_READ:
  - mem_read = 1 and mem_address = miss_addr, both registered.
  - Memory raises mem_busywait in the same cycle that mem_read rises.
  - Go to UPDATE at the first posedge where the FSM has been in MEM_READ for at least 1 cycle and mem_busywait = 0.
  - Ignore pc and read while in this state; the CPU holds pc while busywait = 1.
- UPDATE:
  - mem_read = 0.
  - At posedge, write data[miss index] <= mem_readinst, tag <= miss tag, valid <= 1.
  - Go to IDLE. The next cycle is a hit, so the miss penalty is memory latency + 2 cycles.
- Counters saturate at all-ones and never wrap.
- Reset values, applied asynchronously whenever reset = 0:
  - state IDLE; mem_read 0; mem_address 0; all valid 0; miss_addr 0; counters 0.
  - busywait = 0 and instruction = 0 while read = 0.
  - Data and tag arrays are not reset.
- Reset during MEM_READ:
  - The fill is abandoned and mem_read drops immediately.
  - Any later mem_readinst from that request is ignored, because the FSM is in IDLE and no valid bit is set.
- Conflicting tags on the same index: the new block replaces the old one (no associativity).
- A change of pc while in IDLE with busywait = 0 is a new lookup in the same cycle.

Decomposition:
- Shared package: field positions (TAG_MSB/LSB, INDEX_MSB/LSB, WORD_MSB/LSB), the state encoding (IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2) and BLOCK_W = 128.
- One sub-module is natural: icache_word_select, a pure combinational 128-to-32 mux on the word index.
- The FSM, arrays and counters stay in instruction_cache.

Test Plan:
- Reset, then read = 1, pc = 0x000 → busywait = 1, mem_read = 1, mem_address = 6'd0. After the memory completes (about 16x40 time units), instruction = 32'h00040019 and busywait = 0. miss_count = 1.
- Continue with pc = 0x004, 0x008, 0x00C → each is a same-cycle hit with instruction = 32'h00050023, 32'h02060405, 32'h0001005A. hit_count = 4 (including the post-fill hit on pc = 0x000), mem_read stays 0.
- pc = 0x010 → miss with mem_address = 6'd1, then instruction = 32'h03010104; line 1 becomes valid.
- Conflict: pc = 0x080 (tag 1, index 0) → miss, mem_address = 6'h08, line 0 replaced. Then pc = 0x000 → miss again with mem_address = 6'd0. miss_count increments twice.
- Assert reset = 0 mid-MEM_READ on pc = 0x020 → mem_read = 0 and busywait = 0 immediately, counters = 0. After release, pc = 0x000 → miss (all valid bits cleared).
- read = 0 with any pc → busywait = 0, instruction = 0, mem_read = 0, counters unchanged. Force miss_count to all-ones via 65536 misses (or a reduced CNT_W = 2) → the count holds at max.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_cache_pkg;

    // Fetch address layout: pc = {tag[9:7], index[6:4], word[3:2], byte[1:0]}
    localparam int TAG_MSB   = 9;
    localparam int TAG_LSB   = 7;
    localparam int INDEX_MSB = 6;
    localparam int INDEX_LSB = 4;
    localparam int WORD_MSB  = 3;
    localparam int WORD_LSB  = 2;

    localparam int PC_W       = 10;
    localparam int TAG_W      = TAG_MSB - TAG_LSB + 1;
    localparam int INDEX_W    = INDEX_MSB - INDEX_LSB + 1;
    localparam int WORD_W     = WORD_MSB - WORD_LSB + 1;
    localparam int NUM_BLOCKS = 1 << INDEX_W;
    localparam int MADDR_W    = TAG_W + INDEX_W;
    localparam int BLOCK_W    = 128;
    localparam int INSTR_W    = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_cache_if.sv
// CPU fetch port plus block-read port of the instruction cache.
// Latency: n/a (signal bundle).
// Backpressure: busywait stalls the CPU; mem_busywait stalls the cache.
interface instruction_cache_if #(
    parameter int CNT_W = 16
);
    import instruction_cache_pkg::*;

    // CPU side
    logic                  read;
    logic [PC_W-1:0]       pc;
    logic [INSTR_W-1:0]    instruction;
    logic                  busywait;
    // Instruction memory side
    logic                  mem_read;
    logic [MADDR_W-1:0]    mem_address;
    logic [BLOCK_W-1:0]    mem_readinst;
    logic                  mem_busywait;
    // Statistics
    logic [CNT_W-1:0]      hit_count;
    logic [CNT_W-1:0]      miss_count;

    // master: the cache (serves fetches, initiates block reads)
    modport master (
        input  read, pc, mem_readinst, mem_busywait,
        output instruction, busywait, mem_read, mem_address, hit_count, miss_count
    );

    // slave: CPU + instruction memory environment
    modport slave (
        output read, pc, mem_readinst, mem_busywait,
        input  instruction, busywait, mem_read, mem_address, hit_count, miss_count
    );

endinterface

// File: rtl/instruction_cache_word_select.sv
// Selects one 32-bit instruction word out of a 128-bit cache block.
// Latency: purely combinational.
// Backpressure: none.
module icache_word_select
    import instruction_cache_pkg::*;
(
    input  logic [BLOCK_W-1:0] block,
    input  logic [WORD_W-1:0]  word,
    output logic [INSTR_W-1:0] data
);

    // Word 0 sits in the low bits; bytes are already little-endian in the block.
    always_comb begin
        data = '0;
        case (word)
            2'd0:    data = block[31:0];
            2'd1:    data = block[63:32];
            2'd2:    data = block[95:64];
            default: data = block[127:96];
        endcase
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, 8 lines x 16-byte blocks.
// Latency: hits return in the same cycle; a miss costs memory latency + 2 cycles.
// Backpressure: busywait holds the CPU during a fill; waits on mem_busywait.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,   // asynchronous, active-low
    instruction_cache_if.master  bus
);

    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] pc_index;
    logic [WORD_W-1:0]  pc_word;
    logic [1:0]         pc_unused;

    assign pc_tag    = bus.pc[TAG_MSB:TAG_LSB];
    assign pc_index  = bus.pc[INDEX_MSB:INDEX_LSB];
    assign pc_word   = bus.pc[WORD_MSB:WORD_LSB];
    assign pc_unused = bus.pc[1:0];   // byte offset: fetches are word aligned

    // Storage. Data and tags need no reset: valid_q gates every use of them.
    logic [BLOCK_W-1:0] data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]   tag_q  [NUM_BLOCKS];

    state_t              state_q, state_d;
    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [MADDR_W-1:0]  miss_addr_q, miss_addr_d;
    logic                mem_read_q, mem_read_d;
    logic [MADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic                fill_we;

    logic                hit;
    logic [INSTR_W-1:0]  sel_word;
    logic [INDEX_W-1:0]  miss_index;
    logic [TAG_W-1:0]    miss_tag;

    assign miss_index = miss_addr_q[INDEX_W-1:0];
    assign miss_tag   = miss_addr_q[MADDR_W-1:INDEX_W];

    assign hit = bus.read && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

    icache_word_select u_word_select (
        .block (data_q[pc_index]),
        .word  (pc_word),
        .data  (sel_word)
    );

    assign bus.instruction = hit ? sel_word : '0;
    // Only a hit observed while idle lets the CPU proceed; a stale match
    // during a fill must not release it.
    assign bus.busywait    = bus.read && !((state_q == IDLE) && hit);
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = mem_address_q;
    assign bus.hit_count   = hit_cnt_q;
    assign bus.miss_count  = miss_cnt_q;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        miss_addr_d   = miss_addr_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        fill_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.read) begin
                    if (hit) begin
                        hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
                    end else begin
                        miss_addr_d   = {pc_tag, pc_index};
                        mem_address_d = {pc_tag, pc_index};
                        mem_read_d    = 1'b1;
                        miss_cnt_d    = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
                        state_d       = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                // Any posedge seen in this state is at least one cycle after
                // mem_read rose, so mem_busywait is meaningful here.
                if (!bus.mem_busywait) begin
                    mem_read_d = 1'b0;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                fill_we             = 1'b1;
                valid_d[miss_index] = 1'b1;
                state_d             = IDLE;
            end
            default: begin
                mem_read_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            miss_addr_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            miss_addr_q   <= miss_addr_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_we) begin
            data_q[miss_index] <= bus.mem_readinst;
            tag_q[miss_index]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] instr;
        int          hits;
        int          misses;
    } exp_t;

    logic clock;
    logic reset;

    instruction_cache_if #(.CNT_W(CNT_W)) bus ();

    instruction_cache #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: backing memory plus which block each line holds.
    logic [127:0] mem_blk [64];
    logic         m_valid [8];
    logic [2:0]   m_tag   [8];
    int           m_hit;
    int           m_miss;
    logic         miss_pending;
    logic [5:0]   exp_maddr;
    exp_t         sbq [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    // Instruction memory: raises busywait half a cycle after mem_read,
    // returns the block after a random latency.
    initial begin
        bus.mem_busywait = 1'b0;
        bus.mem_readinst = '0;
        forever begin
            @(negedge clock);
            if (reset && bus.mem_read) begin
                int     lat;
                logic   aborted;
                logic [5:0] a;
                check("spurious_mem_read", miss_pending, 1'b1);
                check("mem_address", bus.mem_address, exp_maddr);
                a = bus.mem_address;
                bus.mem_busywait = 1'b1;
                lat = $urandom_range(1, 5);
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clock);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) bus.mem_readinst = mem_blk[a];
                bus.mem_busywait = 1'b0;
                for (int i = 0; i < 20 && bus.mem_read; i++) @(negedge clock);
                check("mem_read_drop", bus.mem_read, 1'b0);
            end
        end
    end

    // Scoreboard monitor: every completed fetch pops one expectation.
    always @(negedge clock) begin
        if (reset && bus.read && !bus.busywait) begin
            if (sbq.size() == 0) begin
                check("unexpected_fetch", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("instruction", bus.instruction, e.instr);
                check("hit_count", bus.hit_count, e.hits);
                check("miss_count", bus.miss_count, e.misses);
            end
        end
    end

    task automatic fetch(input logic [9:0] p);
        logic hit;
        exp_t e;
        int   n;
        hit = m_valid[p[6:4]] && (m_tag[p[6:4]] == p[9:7]);
        if (!hit) begin
            m_miss       = sat(m_miss);
            miss_pending = 1'b1;
            exp_maddr    = p[9:4];
            m_valid[p[6:4]] = 1'b1;
            m_tag[p[6:4]]   = p[9:7];
        end
        e.instr  = mem_blk[p[9:4]][int'(p[3:2]) * 32 +: 32];
        e.hits   = m_hit;
        e.misses = m_miss;
        sbq.push_back(e);
        bus.pc   = p;
        bus.read = 1'b1;
        #1;
        check("busywait_now", bus.busywait, !hit);
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (!bus.busywait || n >= 60) break;
        end
        check("fetch_done", bus.busywait, 1'b0);
        if (bus.busywait) sbq.delete();
        if (hit) check("hit_latency", n, 1);
        miss_pending = 1'b0;
        m_hit = sat(m_hit);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle(input logic [9:0] p);
        bus.read = 1'b0;
        bus.pc   = p;
        @(negedge clock);
        check("idle_busywait", bus.busywait, 1'b0);
        check("idle_instruction", bus.instruction, 32'h0);
        check("idle_mem_read", bus.mem_read, 1'b0);
        check("idle_hit_count", bus.hit_count, m_hit);
        check("idle_miss_count", bus.miss_count, m_miss);
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
        miss_pending = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++)
            for (int w = 0; w < 4; w++)
                mem_blk[i][w * 32 +: 32] = $urandom;
        mem_blk[0] = {32'h0001005A, 32'h02060405, 32'h00050023, 32'h00040019};
        mem_blk[1][31:0] = 32'h03010104;
        for (int i = 0; i < 8; i++) m_tag[i] = 3'd0;
        model_reset();
        exp_maddr = '0;

        reset    = 1'b0;
        bus.read = 1'b0;
        bus.pc   = '0;
        #5;
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_address", bus.mem_address, 6'd0);
        check("rst_busywait", bus.busywait, 1'b0);
        check("rst_instruction", bus.instruction, 32'h0);
        check("rst_hit_count", bus.hit_count, 0);
        check("rst_miss_count", bus.miss_count, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed: first block, same-cycle hits, second line, conflict.
        fetch(10'h000);
        fetch(10'h004);
        fetch(10'h008);
        fetch(10'h00C);
        check("hit_count_after_block0", bus.hit_count, 4);
        fetch(10'h010);
        fetch(10'h080);
        fetch(10'h000);
        check("miss_count_after_conflict", bus.miss_count, 4);
        idle_cycle(10'h3FF);

        // Reset while a fill is outstanding.
        miss_pending = 1'b1;
        exp_maddr    = 6'h02;
        bus.pc       = 10'h020;
        bus.read     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.mem_read) break;
        end
        check("abort_mem_read_seen", bus.mem_read, 1'b1);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        bus.read = 1'b0;
        #1;
        check("abort_mem_read", bus.mem_read, 1'b0);
        check("abort_busywait", bus.busywait, 1'b0);
        check("abort_hit_count", bus.hit_count, 0);
        check("abort_miss_count", bus.miss_count, 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        fetch(10'h000);
        check("post_reset_miss", bus.miss_count, 1);

        // Random traffic over two tags so both hits and conflicts occur.
        for (int k = 0; k < 300; k++) begin
            logic [9:0] p;
            p = {3'($urandom_range(0, 1)), 7'($urandom)};
            if ($urandom_range(0, 5) == 0) idle_cycle(p);
            else fetch(p);
        end
        if (m_miss == MAXC) check("miss_saturated", bus.miss_count, MAXC);
        if (m_hit == MAXC) check("hit_saturated", bus.hit_count, MAXC);
        check("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
